// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-timer controller and its display path.
// Display-select encoding is consumed by the downstream disp_mux.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    EARLY  = 3'd4,
    SLOW   = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SEL_HI        = 2'd0,
    SEL_COUNT     = 2'd1,
    SEL_ERR_EARLY = 2'd2,
    SEL_ERR_SLOW  = 2'd3
  } disp_sel_t;

  // BCD patterns the display mux shows for the two error outcomes
  localparam logic [15:0] ERR_EARLY_VAL = 16'h9999;
  localparam logic [15:0] ERR_SLOW_VAL  = 16'h1000;

  localparam int REACT_W = 10;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Handshake/status bundle between the reaction-timer controller and its surroundings.
// master = stimulus side (buttons, tick, LFSR); slave = controller.
interface reaction_timer_ctrl_if
  import reaction_timer_pkg::*;
#(
  parameter int RAND_W = 4
);

  logic               start;
  logic               stop;
  logic               tick_ms;
  logic [RAND_W-1:0]  rand_in;
  logic               led;
  logic               blank;
  disp_sel_t          disp_sel;
  logic [REACT_W-1:0] react_ms;
  logic               busy;

  modport master (
    output start, stop, tick_ms, rand_in,
    input  led, blank, disp_sel, react_ms, busy
  );

  modport slave (
    input  start, stop, tick_ms, rand_in,
    output led, blank, disp_sel, react_ms, busy
  );

endinterface

// File: rtl/reaction_timer_ctrl_btn_edge.sv
// Registers a debounced button level and emits a one-cycle rising-edge pulse.
// The history flop resets to 1 so a button held through reset never fires.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn;
    if (reset) begin
      btn_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    btn_q <= btn_d;
  end

  assign pulse = btn & ~btn_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Round sequencer: HI -> random wait -> LED-on reaction timing -> result / error display.
// Outputs are decoded from the state register or come straight from flops.
module reaction_timer_ctrl
  import reaction_timer_pkg::*;
#(
  parameter int MIN_DELAY_S = 2,
  parameter int MAX_MS      = 1000,
  parameter int MS_PER_S    = 1000,
  parameter int RAND_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  reaction_timer_ctrl_if.slave  io
);

  localparam int MS_W = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam logic [MS_W-1:0]    MS_LAST   = MS_W'(MS_PER_S - 1);
  localparam logic [RAND_W-1:0]  MIN_DELAY = RAND_W'(MIN_DELAY_S);
  localparam logic [REACT_W-1:0] MAX_VAL   = REACT_W'(MAX_MS);

  ctrl_state_t        state_q,  state_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [RAND_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [RAND_W-1:0]  delay_s_q, delay_s_d;
  logic [REACT_W-1:0] react_q,  react_d;

  logic start_p;
  logic stop_p;

  btn_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (io.start),
    .pulse (start_p)
  );

  btn_edge u_stop_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (io.stop),
    .pulse (stop_p)
  );

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    sec_cnt_d = sec_cnt_q;
    delay_s_d = delay_s_q;
    react_d   = react_q;

    case (state_q)
      IDLE: begin
        react_d = '0;
        if (start_p) begin
          delay_s_d = (io.rand_in < MIN_DELAY) ? MIN_DELAY : io.rand_in;
          ms_cnt_d  = '0;
          sec_cnt_d = '0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        // An early press beats an expiring delay in the same cycle
        if (stop_p) begin
          state_d = EARLY;
        end else if (sec_cnt_q == delay_s_q) begin
          react_d = '0;
          state_d = TIMING;
        end else if (io.tick_ms) begin
          if (ms_cnt_q == MS_LAST) begin
            ms_cnt_d  = '0;
            sec_cnt_d = sec_cnt_q + 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end

      TIMING: begin
        if (stop_p) begin
          state_d = DONE;
        end else if (io.tick_ms) begin
          if (react_q >= MAX_VAL - 1'b1) begin
            react_d = MAX_VAL;
            state_d = SLOW;
          end else begin
            react_d = react_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (start_p) begin
          react_d = '0;
          state_d = IDLE;
        end
      end

      EARLY: begin
        react_d = '0;
        if (start_p) begin
          state_d = IDLE;
        end
      end

      SLOW: begin
        react_d = MAX_VAL;
        if (start_p) begin
          react_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        ms_cnt_d  = '0;
        sec_cnt_d = '0;
        delay_s_d = '0;
        react_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ms_cnt_q  <= '0;
      sec_cnt_q <= '0;
      delay_s_q <= '0;
      react_q   <= '0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      delay_s_q <= delay_s_d;
      react_q   <= react_d;
    end
  end

  always_comb begin
    io.disp_sel = SEL_HI;
    case (state_q)
      TIMING, DONE: io.disp_sel = SEL_COUNT;
      EARLY:        io.disp_sel = SEL_ERR_EARLY;
      SLOW:         io.disp_sel = SEL_ERR_SLOW;
      default:      io.disp_sel = SEL_HI;
    endcase
  end

  assign io.led      = (state_q == TIMING);
  assign io.blank    = (state_q == WAIT);
  assign io.busy     = (state_q == WAIT) || (state_q == TIMING);
  assign io.react_ms = react_q;

endmodule
